// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions.
// Operand width and the multiplier state encoding.
package mdu_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/serial_mult.sv
// Radix-2 shift-add multiplier, signed or unsigned.
// Result is held with prodv until the next start or reset.
module serial_mult #(
  parameter int WIDTH = mdu_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mst,
  input  logic               msgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic               prodv
);
  import mdu_pkg::*;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             r_state;
  logic               r_sgn;
  logic               r_neg;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH:0]   r_acc;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_neg;
  logic [WIDTH:0]     w_hi;
  logic [2*WIDTH:0]   w_acc_nxt;
  logic [2*WIDTH-1:0] w_res;
  logic [2*WIDTH-1:0] w_prod;

  // Operand magnitudes; |min-int| wraps to itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    w_mag_a = (msgn && a[WIDTH-1]) ? -a : a;
    w_mag_b = (msgn && b[WIDTH-1]) ? -b : b;
    w_neg   = msgn & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  // One shift-add step and the sign-corrected final product.
  always_comb begin
    w_hi = r_acc[2*WIDTH:WIDTH];
    if (r_mplr[0]) begin
      w_hi = r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand};
    end
    w_acc_nxt = {w_hi, r_acc[WIDTH-1:0]} >> 1;
    w_res     = w_acc_nxt[2*WIDTH-1:0];
    w_prod    = r_neg ? -w_res : w_res;
  end

  // Control FSM with registered product outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sgn   <= 1'b0;
      r_neg   <= 1'b0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      prod    <= '0;
      prodv   <= 1'b0;
    end else if (mst) begin
      r_state <= BUSY;
      r_sgn   <= msgn;
      r_neg   <= w_neg;
      r_mcand <= w_mag_a;
      r_mplr  <= w_mag_b;
      r_acc   <= '0;
      r_cnt   <= CW'(WIDTH);
      prodv   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= IDLE;
        end
        BUSY: begin
          r_acc  <= w_acc_nxt;
          r_mplr <= r_mplr >> 1;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            prod    <= w_prod;
            prodv   <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mult.sv
// Directed self-checking bench for serial_mult.
// Hand-computed products, exact latency and hold checks.
module tb_serial_mult;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           mst;
  logic           msgn;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] prod;
  logic           prodv;

  int n_chk;
  int n_err;

  serial_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .mst   (mst),
    .msgn  (msgn),
    .a     (a),
    .b     (b),
    .prod  (prod),
    .prodv (prodv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string          tag,
    input logic [2*W-1:0] got,
    input logic [2*W-1:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue a one-cycle start; returns #1 after the capture edge.
  task automatic start(
    input logic         s,
    input logic [W-1:0] va,
    input logic [W-1:0] vb
  );
    @(negedge clk);
    mst  = 1'b1;
    msgn = s;
    a    = va;
    b    = vb;
    @(posedge clk);
    #1;
    mst = 1'b0;
    a   = $urandom;
    b   = $urandom;
  endtask

  // Wait out the remaining edges and check exact latency/result.
  task automatic finish_op(
    input string          tag,
    input logic [2*W-1:0] exp
  );
    repeat (W - 1) @(posedge clk);
    #1;
    check({tag, "_early"}, {63'd0, prodv}, 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_v"}, {63'd0, prodv}, 64'd1);
    check({tag, "_p"}, prod, exp);
  endtask

  task automatic run(
    input string          tag,
    input logic           s,
    input logic [W-1:0]   va,
    input logic [W-1:0]   vb,
    input logic [2*W-1:0] exp
  );
    start(s, va, vb);
    check({tag, "_cap"}, {63'd0, prodv}, 64'd0);
    finish_op(tag, exp);
  endtask

  logic seen_v;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    mst   = 1'b0;
    msgn  = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("por_prod", prod, 64'd0);
    check("por_v", {63'd0, prodv}, 64'd0);
    rst = 1'b0;

    run("s_big", 1'b1, 32'h3FFF_FFFF, 32'h4000_0000,
        64'h0FFF_FFFF_C000_0000);
    run("s_sq", 1'b1, 32'h3FFF_FFFF, 32'h3FFF_FFFF,
        64'h0FFF_FFFF_8000_0001);
    run("s_small", 1'b1, 32'h0000_0001, 32'h2000_0000,
        64'h0000_0000_2000_0000);

    // Back-to-back restart: prod held across capture.
    start(1'b1, 32'h0000_0001, 32'h2000_0000);
    check("b2b_cap_v", {63'd0, prodv}, 64'd0);
    check("b2b_hold", prod, 64'h0000_0000_2000_0000);
    finish_op("b2b", 64'h0000_0000_2000_0000);

    run("neg1", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001,
        64'hFFFF_FFFF_FFFF_FFFF);
    run("min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000,
        64'h4000_0000_0000_0000);
    run("min_1", 1'b1, 32'h8000_0000, 32'h0000_0001,
        64'hFFFF_FFFF_8000_0000);
    run("m3x5", 1'b1, 32'hFFFF_FFFD, 32'h0000_0005,
        64'hFFFF_FFFF_FFFF_FFF1);
    run("m3xm5", 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB,
        64'h0000_0000_0000_000F);
    run("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        64'hFFFF_FFFE_0000_0001);
    run("u_x2", 1'b0, 32'h8000_0000, 32'h0000_0002,
        64'h0000_0001_0000_0000);

    // DONE hold with input churn.
    repeat (20) begin
      @(negedge clk);
      a    = $urandom;
      b    = $urandom;
      msgn = ~msgn;
    end
    #1;
    check("hold_v", {63'd0, prodv}, 64'd1);
    check("hold_p", prod, 64'h0000_0001_0000_0000);

    // Abort at clock 10 and restart with 3*5.
    start(1'b1, 32'h3FFF_FFFF, 32'h3FFF_FFFF);
    repeat (9) @(posedge clk);
    seen_v = prodv;
    run("abort", 1'b1, 32'h0000_0003, 32'h0000_0005,
        64'h0000_0000_0000_000F);
    check("abort_nov", {63'd0, seen_v}, 64'd0);

    // Reset mid-operation at clock 15.
    start(1'b1, 32'h3FFF_FFFF, 32'h3FFF_FFFF);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_prod", prod, 64'd0);
    check("rst_v", {63'd0, prodv}, 64'd0);
    seen_v = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen_v = seen_v | prodv;
    end
    check("rst_idle", {63'd0, seen_v}, 64'd0);
    check("rst_prod2", prod, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
